// File: rtl/ripple_count_sampler.sv
// Synchronises and de-glitches an asynchronous ripple-counter bus, extends it with a wrap counter
// and raises a programmable match interrupt. Define RIPPLE_SAMPLER_SKIP_DET_EN to add the sticky skip_err output.
module ripple_count_sampler #(
    parameter int WIDTH         = 4,
    parameter int EXT_WIDTH     = 8,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           cnt_in,
    input  logic                       match_en,
    input  logic [WIDTH+EXT_WIDTH-1:0] match_val,
    input  logic                       ack,
    output logic [WIDTH+EXT_WIDTH-1:0] count_out,
    output logic                       count_vld,
    output logic                       wrap,
    output logic                       match_irq
`ifdef RIPPLE_SAMPLER_SKIP_DET_EN
    ,
    output logic                       skip_err
`endif
);

    localparam int RW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [RW-1:0] R_MAX = RW'(STABLE_CYCLES);

    logic [WIDTH-1:0]     s1_p0;
    logic [WIDTH-1:0]     s2_p1;
    logic [RW-1:0]        run_p2;
    logic [WIDTH-1:0]     acc;
    logic [EXT_WIDTH-1:0] ext;

    logic                 accept;
    logic                 is_wrap;
    logic [EXT_WIDTH-1:0] ext_nxt;
    logic                 hit;

    // Run length saturates so a long-stable bus keeps the accept window open.
    function automatic logic [RW-1:0] sat_inc(input logic [RW-1:0] v);
        return (v >= R_MAX) ? R_MAX : v + RW'(1);
    endfunction

    assign accept  = (run_p2 == R_MAX) && (s2_p1 != acc);
    assign is_wrap = accept && (acc == {WIDTH{1'b1}}) && (s2_p1 == '0);
    assign ext_nxt = is_wrap ? ext + EXT_WIDTH'(1) : ext;
    assign hit     = accept && match_en && ({ext_nxt, s2_p1} == match_val);

    assign count_out = {ext, acc};

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            s1_p0     <= '0;
            s2_p1     <= '0;
            run_p2    <= '0;
            acc       <= '0;
            ext       <= '0;
            count_vld <= 1'b0;
            wrap      <= 1'b0;
            match_irq <= 1'b0;
        end else begin
            // p0/p1: two-flop synchroniser; p2: stability run length
            s1_p0     <= cnt_in;
            s2_p1     <= s1_p0;
            run_p2    <= (s1_p0 == s2_p1) ? sat_inc(run_p2) : '0;
            count_vld <= accept;
            wrap      <= is_wrap;
            if (accept) begin
                acc <= s2_p1;
                ext <= ext_nxt;
            end
            // A coincident match wins over ack.
            if (hit)
                match_irq <= 1'b1;
            else if (ack)
                match_irq <= 1'b0;
        end
    end

`ifdef RIPPLE_SAMPLER_SKIP_DET_EN
    logic [WIDTH-1:0] acc_inc;
    logic             is_skip;

    assign acc_inc = acc + WIDTH'(1);
    assign is_skip = accept && (s2_p1 != acc_inc);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear)
            skip_err <= 1'b0;
        else if (is_skip)
            skip_err <= 1'b1;
    end
`endif

endmodule

// File: doc/ripple_count_sampler.md
Name: ripple_count_sampler

Overview:
Downstream consumer of the 4-bit asynchronous ripple counter. It synchronises the counter's skewed, glitchy q bus into the clk domain and filters ripple transients. It accepts only stable values and extends the count with a wrap counter. It produces a clean registered count, change/wrap strobes and a programmable match interrupt for the rest of the synchronous design.

Parameters:
WIDTH, 4, width of the ripple counter bus cnt_in
EXT_WIDTH, 8, width of the wrap-extension counter (upper bits of count_out)
STABLE_CYCLES, 2, consecutive equal synchronised samples required before a value is accepted (>=1)

Ports:
clk  input  1  sampling clock, rising edge
clear  input  1  asynchronous, active-low reset
cnt_in  input  WIDTH  ripple counter q bus, asynchronous to clk
match_en  input  1  enables match detection
match_val  input  WIDTH+EXT_WIDTH  match compare value (quasi-static)
ack  input  1  clears match_irq
count_out  output  WIDTH+EXT_WIDTH  {ext, acc}: extended accepted count
count_vld  output  1  one-cycle pulse when count_out changes
wrap  output  1  one-cycle pulse when acc wraps max->0
match_irq  output  1  level, set on match, held until ack

Behaviour:
- Reset (clear=0, asynchronous): s1, s2, r, acc, ext, count_vld, wrap, match_irq and skip_err are all 0 immediately, independent of clk. Asserting clear mid-operation aborts any pending acceptance.
- Synchroniser: each edge s2<=s1, s1<=cnt_in (2-flop, per bit).
- Stability run counter r (0..STABLE_CYCLES): each edge r <= (s1==s2) ? min(r+1, STABLE_CYCLES) : 0.
- Accept condition (evaluated before edge): r==STABLE_CYCLES and s2!=acc. At that edge acc<=s2 and count_vld<=1 for exactly one cycle. Otherwise count_vld<=0.
- Latency: cnt_in stable from before edge 0 -> count_out updates at edge STABLE_CYCLES+2 (default edge 4).
- Transients: any value held for fewer than STABLE_CYCLES+1 consecutive samples is never accepted.
- Accept classification (old=acc, new=s2):
  - new==old+1 (mod 2^WIDTH), old!=max: normal increment; ext unchanged.
  - old==2^WIDTH-1 and new==0: wrap. ext<=ext+1 (mod 2^EXT_WIDTH, silent rollover). wrap pulses in the same cycle as count_vld.
  - any other change is a skip (e.g. upstream cleared, missed count): acc<=new, ext unchanged, wrap stays 0.
- Match: on an accept edge, if match_en and the new {ext,acc}==match_val, match_irq<=1.
  - ack=1 clears match_irq at the next edge.
  - A new match and ack in the same cycle: set wins, match_irq stays 1.
  - match_en low never clears an already-set match_irq.
- No accept ever occurs while acc already equals s2. After reset with cnt_in=0, no strobe is produced.

Optional Feature:
Macro RIPPLE_SAMPLER_SKIP_DET_EN.
- Defined: adds output port skip_err (1 bit, sticky). It sets at the accept edge of any skip-class change and clears only on clear.
- Undefined: port absent; skip-class changes are accepted silently with identical acc/ext behaviour.

Test Plan:
1. clear=0 pulse with clk stopped: all outputs 0 asynchronously. Release with cnt_in=0 and run 20 cycles: count_vld never asserts, count_out=0.
2. cnt_in 0->1 held: count_out=0x001 at edge 4 after the change, count_vld high exactly one cycle, wrap=0.
3. Step cnt_in through 1..15 with each value held 6 cycles, then 0: at the 0 accept count_out=0x010, wrap and count_vld pulse together.
4. Glitch: acc=3, cnt_in=7 for 2 cycles then back to 3: no count_vld. Then cnt_in=4 held: count_out low bits=4, one count_vld.
5. match_val=0x012, match_en=1, count up through 0x012: match_irq rises with that count_vld and holds. ack pulse clears it one edge later. ack coincident with a new match leaves match_irq=1.
6. acc=5, cnt_in=9 held: count_out low bits=9, ext unchanged, wrap=0, skip_err=1 (macro defined). Assert clear mid-run: all outputs 0 immediately, skip_err cleared.
